// File: rtl/core_pkg.sv
// Shared core types: datapath width, result-select encoding and load funct3 codes.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Byte/half/word extraction with sign or zero extension from an aligned memory word.
module load_extend
    import core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        // off[0] is not looked at for halves; misaligned halves never get this far
        half_sel = off[1] ? word[31:16] : word[15:0];
        data     = '0;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h0, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0, half_sel};
            F3_LW:   data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, result select, register-file write port, forwarding and instret.
module writeback_stage
    import core_pkg::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 m_valid,
    input  logic                 m_reg_write,
    input  logic [4:0]           m_rd,
    input  logic [1:0]           m_result_src,
    input  logic [2:0]           m_funct3,
    input  logic [XLEN-1:0]      m_alu_result,
    input  logic [XLEN-1:0]      m_pc_plus4,
    input  logic [XLEN-1:0]      m_load_word,
    output logic                 rf_we,
    output logic [4:0]           rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_rd,
    output logic [XLEN-1:0]      fwd_data,
    output logic [INSTRET_W-1:0] instret
);

    logic                 w_valid_q,       w_valid_d;
    logic                 w_reg_write_q,   w_reg_write_d;
    logic [4:0]           w_rd_q,          w_rd_d;
    logic [1:0]           w_result_src_q,  w_result_src_d;
    logic [2:0]           w_funct3_q,      w_funct3_d;
    logic [XLEN-1:0]      w_alu_result_q,  w_alu_result_d;
    logic [XLEN-1:0]      w_pc_plus4_q,    w_pc_plus4_d;
    logic [XLEN-1:0]      w_load_word_q,   w_load_word_d;
    logic [INSTRET_W-1:0] instret_q,       instret_d;

    logic            wr_ok;
    logic            commit;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result;

    load_extend u_load_extend (
        .funct3 (w_funct3_q),
        .off    (w_alu_result_q[1:0]),
        .word   (w_load_word_q),
        .data   (load_data)
    );

    always_comb begin
        w_valid_d      = w_valid_q;
        w_reg_write_d  = w_reg_write_q;
        w_rd_d         = w_rd_q;
        w_result_src_d = w_result_src_q;
        w_funct3_d     = w_funct3_q;
        w_alu_result_d = w_alu_result_q;
        w_pc_plus4_d   = w_pc_plus4_q;
        w_load_word_d  = w_load_word_q;
        if (flush) begin
            w_valid_d = 1'b0;
        end else if (!stall) begin
            w_valid_d      = m_valid;
            w_reg_write_d  = m_reg_write;
            w_rd_d         = m_rd;
            w_result_src_d = m_result_src;
            w_funct3_d     = m_funct3;
            w_alu_result_d = m_alu_result;
            w_pc_plus4_d   = m_pc_plus4;
            w_load_word_d  = m_load_word;
        end
    end

    always_comb begin
        // reset drops the resident instruction without writing or counting it
        commit = w_valid_q & ~stall & ~reset;
        wr_ok  = w_valid_q & w_reg_write_q & (w_rd_q != 5'd0);
        result = '0;
        case (result_src_t'(w_result_src_q))
            RES_ALU:  result = w_alu_result_q;
            RES_LOAD: result = load_data;
            RES_PC4:  result = w_pc_plus4_q;
            default:  result = '0;
        endcase
        instret_d = commit ? instret_q + INSTRET_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_valid_q <= 1'b0;
            instret_q <= '0;
        end else begin
            w_valid_q <= w_valid_d;
            instret_q <= instret_d;
        end
    end

    always_ff @(posedge clk) begin
        w_reg_write_q  <= w_reg_write_d;
        w_rd_q         <= w_rd_d;
        w_result_src_q <= w_result_src_d;
        w_funct3_q     <= w_funct3_d;
        w_alu_result_q <= w_alu_result_d;
        w_pc_plus4_q   <= w_pc_plus4_d;
        w_load_word_q  <= w_load_word_d;
    end

    assign rf_we     = wr_ok & ~stall & ~reset;
    assign rf_wa     = w_rd_q;
    assign rf_wd     = result;
    assign fwd_valid = wr_ok;
    assign fwd_rd    = w_rd_q;
    assign fwd_data  = result;
    assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a second 4-bit-instret instance exercises counter wrap.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        m_valid, m_reg_write;
    logic [4:0]  m_rd;
    logic [1:0]  m_result_src;
    logic [2:0]  m_funct3;
    logic [31:0] m_alu_result, m_pc_plus4, m_load_word;

    logic        rf_we, fwd_valid, rf_we_w, fwd_valid_w;
    logic [4:0]  rf_wa, fwd_rd, rf_wa_w, fwd_rd_w;
    logic [31:0] rf_wd, fwd_data, rf_wd_w, fwd_data_w;
    logic [63:0] instret;
    logic [3:0]  instret_w;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_ret;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
        .m_result_src(m_result_src), .m_funct3(m_funct3),
        .m_alu_result(m_alu_result), .m_pc_plus4(m_pc_plus4), .m_load_word(m_load_word),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .instret(instret)
    );

    writeback_stage #(.INSTRET_W(4)) dut_w (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
        .m_result_src(m_result_src), .m_funct3(m_funct3),
        .m_alu_result(m_alu_result), .m_pc_plus4(m_pc_plus4), .m_load_word(m_load_word),
        .rf_we(rf_we_w), .rf_wa(rf_wa_w), .rf_wd(rf_wd_w),
        .fwd_valid(fwd_valid_w), .fwd_rd(fwd_rd_w), .fwd_data(fwd_data_w),
        .instret(instret_w)
    );

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] word;
        logic        exp_we;
        logic        exp_fv;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_ret(input string name);
        chk({name, "_instret"}, instret, exp_ret);
        chk({name, "_instret_w"}, {60'h0, instret_w}, {60'h0, exp_ret[3:0]});
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] word);
        m_valid = v; m_reg_write = rw; m_rd = rd; m_result_src = src;
        m_funct3 = f3; m_alu_result = alu; m_pc_plus4 = pc4; m_load_word = word;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //          valid rw rd     src    f3      alu           pc4           word          we    fv    wd
        vecs[0]  = '{1'b1,1'b1,5'd5, 2'b01,3'b010,32'h0000_0100,32'h0,        32'hDEAD_BEEF,1'b1,1'b1,32'hDEAD_BEEF};
        vecs[1]  = '{1'b1,1'b1,5'd6, 2'b01,3'b000,32'h0000_0203,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'hFFFF_FF80};
        vecs[2]  = '{1'b1,1'b1,5'd7, 2'b01,3'b100,32'h0000_0201,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'h0000_007F};
        vecs[3]  = '{1'b1,1'b1,5'd8, 2'b01,3'b001,32'h0000_0202,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'hFFFF_80FF};
        vecs[4]  = '{1'b1,1'b1,5'd9, 2'b01,3'b101,32'h0000_0200,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'h0000_7F01};
        vecs[5]  = '{1'b1,1'b1,5'd0, 2'b00,3'b000,32'h0000_1234,32'h0,        32'h0,        1'b0,1'b0,32'h0000_1234};
        vecs[6]  = '{1'b1,1'b1,5'd1, 2'b10,3'b000,32'h0000_5555,32'h0000_0104,32'h0,        1'b1,1'b1,32'h0000_0104};
        vecs[7]  = '{1'b1,1'b1,5'd10,2'b01,3'b011,32'h0000_0300,32'h0,        32'hFFFF_FFFF,1'b1,1'b1,32'h0000_0000};
        vecs[8]  = '{1'b1,1'b1,5'd11,2'b11,3'b010,32'h0000_7777,32'h0000_0008,32'hFFFF_FFFF,1'b1,1'b1,32'h0000_0000};
        vecs[9]  = '{1'b0,1'b1,5'd12,2'b00,3'b000,32'h0000_9999,32'h0,        32'h0,        1'b0,1'b0,32'h0000_9999};
        vecs[10] = '{1'b1,1'b0,5'd13,2'b00,3'b000,32'h0000_AAAA,32'h0,        32'h0,        1'b0,1'b0,32'h0000_AAAA};
        vecs[11] = '{1'b1,1'b1,5'd14,2'b01,3'b001,32'h0000_0403,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'hFFFF_80FF};
        vecs[12] = '{1'b1,1'b1,5'd15,2'b01,3'b000,32'h0000_0400,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'h0000_0001};
        vecs[13] = '{1'b1,1'b1,5'd31,2'b01,3'b100,32'h0000_0402,32'h0,        32'h80FF_7F01,1'b1,1'b1,32'h0000_00FF};

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        exp_ret = 64'd0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("reset_rf_we", {63'h0, rf_we}, 64'd0);
        chk("reset_fwd_valid", {63'h0, fwd_valid}, 64'd0);
        chk_ret("reset");

        // Table-driven: each vector is written one edge after capture
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].src, vecs[i].f3,
                  vecs[i].alu, vecs[i].pc4, vecs[i].word);
            cyc();
            chk($sformatf("v%0d_rf_we", i), {63'h0, rf_we}, {63'h0, vecs[i].exp_we});
            chk($sformatf("v%0d_fwd_valid", i), {63'h0, fwd_valid}, {63'h0, vecs[i].exp_fv});
            if (vecs[i].exp_we) begin
                chk($sformatf("v%0d_rf_wa", i), {59'h0, rf_wa}, {59'h0, vecs[i].rd});
                chk($sformatf("v%0d_rf_wd", i), {32'h0, rf_wd}, {32'h0, vecs[i].exp_wd});
            end
            if (vecs[i].exp_fv) begin
                chk($sformatf("v%0d_fwd_rd", i), {59'h0, fwd_rd}, {59'h0, vecs[i].rd});
                chk($sformatf("v%0d_fwd_data", i), {32'h0, fwd_data}, {32'h0, vecs[i].exp_wd});
            end
            chk_ret($sformatf("v%0d", i));
            if (vecs[i].valid) exp_ret = exp_ret + 64'd1;
        end
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        cyc();
        chk_ret("drain");

        // Stall hold: A sits in WB for three stalled edges, then commits once
        drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'h0000_AAAA, 32'h0, 32'h0);
        cyc();
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_BBBB, 32'h0, 32'h0);
        #1;
        chk("stall0_rf_we", {63'h0, rf_we}, 64'd0);
        chk("stall0_fwd_valid", {63'h0, fwd_valid}, 64'd1);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk($sformatf("stall%0d_rf_we", k), {63'h0, rf_we}, 64'd0);
            chk($sformatf("stall%0d_fwd_valid", k), {63'h0, fwd_valid}, 64'd1);
            chk($sformatf("stall%0d_fwd_rd", k), {59'h0, fwd_rd}, 64'd12);
            chk($sformatf("stall%0d_fwd_data", k), {32'h0, fwd_data}, 64'h0000_AAAA);
            chk_ret($sformatf("stall%0d", k));
        end
        stall = 1'b0;
        #1;
        chk("unstall_rf_we", {63'h0, rf_we}, 64'd1);
        chk("unstall_rf_wa", {59'h0, rf_wa}, 64'd12);
        chk("unstall_rf_wd", {32'h0, rf_wd}, 64'h0000_AAAA);
        cyc();
        exp_ret = exp_ret + 64'd1;
        chk_ret("unstall");
        chk("next_rf_wa", {59'h0, rf_wa}, 64'd13);
        chk("next_rf_wd", {32'h0, rf_wd}, 64'h0000_BBBB);
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        cyc();
        exp_ret = exp_ret + 64'd1;
        chk_ret("next_commit");

        // Flush wins over stall on the same edge
        drive(1'b1, 1'b1, 5'd14, 2'b00, 3'b000, 32'h0000_CCCC, 32'h0, 32'h0);
        flush = 1'b1; stall = 1'b1;
        cyc();
        flush = 1'b0; stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        #1;
        chk("flush_rf_we", {63'h0, rf_we}, 64'd0);
        chk("flush_fwd_valid", {63'h0, fwd_valid}, 64'd0);
        cyc();
        chk_ret("flush");

        // Back-to-back commits carry the 4-bit counter past 15
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
            cyc();
            chk_ret($sformatf("b2b%0d", k));
            exp_ret = exp_ret + 64'd1;
        end
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        cyc();
        chk_ret("wrap");
        chk("wrap_crossed", {63'h0, (exp_ret > 64'd16)}, 64'd1);

        // Reset while a valid write sits in WB
        drive(1'b1, 1'b1, 5'd15, 2'b00, 3'b000, 32'h0000_DDDD, 32'h0, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        chk("prerst_rf_we", {63'h0, rf_we}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_rf_we_same", {63'h0, rf_we}, 64'd0);
        cyc();
        exp_ret = 64'd0;
        chk("rst_rf_we", {63'h0, rf_we}, 64'd0);
        chk("rst_fwd_valid", {63'h0, fwd_valid}, 64'd0);
        chk_ret("rst");
        reset = 1'b0;
        cyc();
        chk("postrst_rf_we", {63'h0, rf_we}, 64'd0);
        chk_ret("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register and writeback logic for the core.
- Captures the memory-stage result each cycle and extracts sign- or zero-extended load data from the raw data-memory word.
- Selects the final result and drives the register file write port (we3/wa3/wd3) directly.
- Also provides a same-cycle forwarding source for the execute stage and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- INSTRET_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  pipeline freeze; holds the WB register and blocks commit
- flush  in  1  kills the incoming instruction; inserts a bubble
- m_valid  in  1  memory stage holds a valid instruction
- m_reg_write  in  1  instruction writes rd
- m_rd  in  5  destination register
- m_result_src  in  2  result select (package enum)
- m_funct3  in  3  load width/sign code
- m_alu_result  in  XLEN  ALU result; also the load address
- m_pc_plus4  in  XLEN  link value
- m_load_word  in  XLEN  raw aligned 32-bit word from data memory
- rf_we  out  1  register file write enable (to we3)
- rf_wa  out  5  register file write address (to wa3)
- rf_wd  out  XLEN  register file write data (to wd3)
- fwd_valid  out  1  forwarding entry valid
- fwd_rd  out  5  forwarding destination
- fwd_data  out  XLEN  forwarding value
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- WB register update, at every posedge clk:
  - reset=1: w_valid<=0, instret<=0. Other fields are don't-care.
  - else if flush=1: w_valid<=0. Flush wins over stall.
  - else if stall=0: capture all m_* fields, w_valid<=m_valid.
  - else (stall=1): hold all fields.
- Load extract, combinational from the WB register:
  - off = w_alu_result[1:0].
  - LB (000): sign-extend byte[off].
  - LBU (100): zero-extend byte[off].
  - LH (001): sign-extend half[off[1]]; off[0] is ignored because misalignment is trapped upstream.
  - LHU (101): zero-extend half[off[1]].
  - LW (010): the word unchanged.
  - Any other funct3: 0.
- Result select:
  - RES_ALU (00): w_alu_result.
  - RES_LOAD (01): extracted load data.
  - RES_PC4 (10): w_pc_plus4.
  - RES_RSVD (11): 0.
- Writable: wr_ok = w_valid & w_reg_write & (w_rd != 0).
- Commit: commit = w_valid & ~stall.
  - Each instruction commits exactly once, in the first cycle of its WB residency with stall=0. The WB register advances at that same edge.
- Register file port:
  - rf_we = wr_ok & ~stall.
  - rf_wa = w_rd.
  - rf_wd = selected result.
  - rf_we is never 1 for rd=0.
- Forwarding:
  - fwd_valid = wr_ok, independent of stall.
  - fwd_rd = w_rd, fwd_data = selected result.
  - When fwd_valid=0, fwd_rd and fwd_data are don't-care.
- instret:
  - +1 on each edge where commit=1, regardless of reg_write. Stores and branches count.
  - Wraps modulo 2^INSTRET_W.
  - reset has priority over increment.
- Latency: an instruction present at the m_* inputs at edge N is written to the register file at edge N+1, provided stall=0 in the cycle after N.
- Reset mid-operation: the in-flight instruction is dropped, not committed, and not counted.
- After reset release, outputs are valid from the first cycle:
  - rf_we=0, fwd_valid=0, instret=0.
  - rf_wa, rf_wd and fwd_data are don't-care while their enables are 0.

Decomposition:
- Shared package core_pkg holds:
  - result_src_t enum: RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10, RES_RSVD=2'b11.
  - funct3 load constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - XLEN.
- One sub-module: load_extend. Purely combinational; inputs funct3, off, word; output the extended value. It is reused by any later cache or LSU work.

Test Plan:
- LW commit: m_valid=1, rd=5, RES_LOAD, funct3=010, word=0xDEADBEEF, stall=0 -> next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF, instret 0->1.
- Byte/half extract: word=0x80FF7F01 with LB off=3 -> 0xFFFFFF80; LBU off=1 -> 0x0000007F; LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
- x0 suppression and link:
  - rd=0, reg_write=1, ALU=0x1234 -> rf_we=0, fwd_valid=0, instret still increments.
  - RES_PC4 with pc_plus4=0x104, rd=1 -> rf_wd=0x104.
- Stall hold:
  - Instruction enters WB, then stall=1 for 3 cycles -> rf_we=0 and fwd_valid=1 throughout; instret unchanged.
  - Stall drops -> single write and instret +1.
  - Next m_* instruction captured at that edge.
- Flush vs stall: flush=1 and stall=1 on the same edge with m_valid=1 -> w_valid=0 next cycle; no write, no count.
- Reset and wrap:
  - Force instret to 2^64-1, then commit -> instret=0.
  - Assert reset while a valid write sits in WB -> no write that cycle onward; instret=0.
